// File: rtl/line_word_converter.sv
// line_word_converter: cache line <-> word stream converter with critical-word-first wrap-around
module line_word_converter #(
    parameter int LINE_W = 256,
    parameter int WORD_W = 32,
    parameter int IDX_W  = $clog2(LINE_W / WORD_W)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_mode,
    input  logic [IDX_W-1:0]  ld_offset,
    input  logic [LINE_W-1:0] ld_line,
    output logic              wo_valid,
    input  logic              wo_ready,
    output logic [WORD_W-1:0] wo_data,
    output logic [IDX_W-1:0]  wo_idx,
    output logic              wo_last,
    input  logic              wi_valid,
    output logic              wi_ready,
    input  logic [WORD_W-1:0] wi_data,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [LINE_W-1:0] line_data,
    output logic              busy
);
    localparam logic [IDX_W:0] LAST = (IDX_W + 1)'(LINE_W / WORD_W - 1);
    typedef enum logic [1:0] {IDLE, SER, DES, LOUT} state_t;
    state_t state, state_nxt;
    logic [LINE_W-1:0] line_reg;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W:0]    cnt;
    logic              ser, des;
    assign ser        = state == SER;
    assign des        = state == DES;
    assign ld_ready   = state == IDLE;
    assign busy       = !ld_ready;
    assign wo_valid   = ser;
    assign wo_data    = ser ? line_reg[idx*WORD_W +: WORD_W] : '0;
    assign wo_idx     = ser ? idx : '0;
    assign wo_last    = ser && cnt == LAST;
    assign wi_ready   = des;
    assign line_valid = state == LOUT;
    assign line_data  = line_reg;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ld_valid ? (ld_mode ? DES : SER) : IDLE;
            SER:     state_nxt = (wo_ready && wo_last) ? IDLE : SER;
            DES:     state_nxt = (wi_valid && cnt == LAST) ? LOUT : DES;
            LOUT:    state_nxt = line_ready ? IDLE : LOUT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            line_reg <= '0;
            idx      <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (ld_ready && ld_valid) begin
                idx      <= ld_offset;
                cnt      <= '0;
                line_reg <= ld_mode ? '0 : ld_line;
            end
            if ((ser && wo_ready) || (des && wi_valid)) begin
                idx <= idx + 1'b1;
                cnt <= cnt + 1'b1;
            end
            if (des && wi_valid)
                line_reg[idx*WORD_W +: WORD_W] <= wi_data;
        end
    end
endmodule

// File: tb/tb_line_word_converter.sv
// tb_line_word_converter: directed self-checking bench for line_word_converter
module tb_line_word_converter;
    localparam logic [255:0] L = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    localparam logic [255:0] DES_EXP = 256'h000000A4_000000A3_000000A2_000000A1_000000A0_000000A7_000000A6_000000A5;
    logic         CLK = 1'b0;
    logic         RST_N;
    logic         ld_valid, ld_ready, ld_mode;
    logic [2:0]   ld_offset;
    logic [255:0] ld_line;
    logic         wo_valid, wo_ready, wo_last;
    logic [31:0]  wo_data;
    logic [2:0]   wo_idx;
    logic         wi_valid, wi_ready;
    logic [31:0]  wi_data;
    logic         line_valid, line_ready;
    logic [255:0] line_data;
    logic         busy;
    int           n_checks = 0;
    int           n_errors = 0;
    line_word_converter dut (
        .CLK(CLK), .RST_N(RST_N),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_mode(ld_mode),
        .ld_offset(ld_offset), .ld_line(ld_line),
        .wo_valid(wo_valid), .wo_ready(wo_ready), .wo_data(wo_data),
        .wo_idx(wo_idx), .wo_last(wo_last),
        .wi_valid(wi_valid), .wi_ready(wi_ready), .wi_data(wi_data),
        .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
        .busy(busy)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_word(input int i);
        return {8{4'(8 - i)}};
    endfunction
    task automatic idle_checks(input string tag);
        check({tag, " ld_ready"}, ld_ready, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " wo_valid"}, wo_valid, 0);
        check({tag, " wi_ready"}, wi_ready, 0);
        check({tag, " line_valid"}, line_valid, 0);
    endtask
    task automatic run_ser(input logic [2:0] off, input logic [15:0] pat, input logic poke, input string tag);
        int k = 0;
        int cyc = 0;
        ld_valid = 1; ld_mode = 0; ld_offset = off; ld_line = L; wo_ready = 0;
        @(negedge CLK);
        while (k < 8 && cyc < 40) begin
            ld_valid = poke; ld_mode = 1; ld_offset = ~off; ld_line = ~L;
            wo_ready = pat[cyc % 16];
            check({tag, " wo_valid"}, wo_valid, 1);
            check({tag, " wo_idx"}, wo_idx, 3'(off + k));
            check({tag, " wo_data"}, wo_data, exp_word(int'(3'(off + k))));
            check({tag, " wo_last"}, wo_last, k == 7);
            @(negedge CLK);
            if (wo_ready) k++;
            cyc++;
        end
        ld_valid = 0; ld_line = L; wo_ready = 0;
        check({tag, " transfers"}, k, 8);
        idle_checks({tag, " end"});
    endtask
    initial begin
        RST_N = 0; ld_valid = 0; ld_mode = 0; ld_offset = 0; ld_line = L;
        wo_ready = 0; wi_valid = 0; wi_data = 0; line_ready = 0;
        repeat (2) @(negedge CLK);
        idle_checks("reset");
        check("reset wo_data", wo_data, 0);
        check("reset wo_last", wo_last, 0);
        check("reset line_data", line_data, 0);
        RST_N = 1;
        @(negedge CLK);
        run_ser(3'd0, 16'hFFFF, 0, "ser0");
        @(negedge CLK);
        run_ser(3'd6, 16'hFFFF, 0, "wrap");
        @(negedge CLK);
        run_ser(3'd0, 16'h9999, 0, "bp");
        wi_valid = 1; wi_data = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge CLK);
            idle_checks("idle wi_valid");
        end
        run_ser(3'd4, 16'hFFFF, 1, "ignore");
        wi_valid = 0;
        @(negedge CLK);
        begin
            logic [7:0] gaps = 8'b1011_0101;
            int k = 0;
            int cyc = 0;
            ld_valid = 1; ld_mode = 1; ld_offset = 3'd3;
            @(negedge CLK);
            ld_valid = 0;
            while (k < 8 && cyc < 40) begin
                wi_valid = gaps[cyc % 8] || cyc > 16;
                wi_data = 32'hA0 + 32'(k);
                check("des wi_ready", wi_ready, 1);
                check("des line_valid", line_valid, 0);
                @(negedge CLK);
                if (wi_valid) k++;
                cyc++;
            end
            wi_valid = 0;
            check("des words", k, 8);
            repeat (3) begin
                check("des hold line_valid", line_valid, 1);
                check("des hold wi_ready", wi_ready, 0);
                check("des line_data", line_data, DES_EXP);
                @(negedge CLK);
            end
            line_ready = 1;
            check("des final line_data", line_data, DES_EXP);
            @(negedge CLK);
            line_ready = 0;
            idle_checks("des end");
        end
        ld_valid = 1; ld_mode = 0; ld_offset = 3'd2; wo_ready = 1;
        @(negedge CLK);
        ld_valid = 0;
        for (int k = 0; k < 3; k++) begin
            check("mid wo_data", wo_data, exp_word(2 + k));
            @(negedge CLK);
        end
        RST_N = 0; wo_ready = 0;
        @(negedge CLK);
        RST_N = 1;
        idle_checks("mid reset");
        run_ser(3'd5, 16'hFFFF, 0, "post reset");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/line_word_converter.md
Name: line_word_converter

Overview:
- Parametrised successor to the cache-line serializer; sits between the cache line buffer and the word-wide memory/bus port.
- Serialize mode: accepts a full cache line and emits it as a stream of words.
- Deserialize mode: collects a stream of words and emits a full cache line.
- Both sides use valid/ready handshakes. A programmable start offset gives critical-word-first ordering with wrap-around.

Parameters:
- LINE_W, 256, cache line width in bits.
- WORD_W, 32, bus word width in bits. LINE_W/WORD_W = N must be an integer power of two, N >= 2.
- IDX_W, $clog2(LINE_W/WORD_W), word index width (derived; do not override).

Ports:
- CLK  in  1  system clock, all logic on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- ld_valid  in  1  transaction request.
- ld_ready  out  1  block idle, can accept a request.
- ld_mode  in  1  0 = serialize (line->words), 1 = deserialize (words->line).
- ld_offset  in  IDX_W  first word index of the transaction.
- ld_line  in  LINE_W  line to serialize (ignored in deserialize mode).
- wo_valid  out  1  output word valid.
- wo_ready  in  1  downstream accepts output word.
- wo_data  out  WORD_W  output word.
- wo_idx  out  IDX_W  line index of wo_data.
- wo_last  out  1  current output word is the Nth of the transaction.
- wi_valid  in  1  input word valid.
- wi_ready  out  1  block accepts input word.
- wi_data  in  WORD_W  input word.
- line_valid  out  1  assembled line valid.
- line_ready  in  1  consumer accepts assembled line.
- line_data  out  LINE_W  assembled line.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Word i of a line is line[i*WORD_W +: WORD_W]. Word 0 is the least significant word.
- FSM states: IDLE, SER, DES, LOUT. Internal regs: line_reg[LINE_W], idx[IDX_W], cnt[IDX_W+1].
- Reset (RST_N=0 at a clock edge):
  - State goes to IDLE; line_reg, idx, cnt clear to 0.
  - All outputs go to 0 except ld_ready=1.
  - Reset applies from any state, including mid-transaction; the partial transaction is discarded with no further handshakes.
- IDLE:
  - ld_ready=1; wo_valid=wi_ready=line_valid=0; busy=0.
  - On ld_valid&&ld_ready: idx<=ld_offset, cnt<=0.
  - If ld_mode=0: line_reg<=ld_line, next state SER.
  - If ld_mode=1: line_reg<=0, next state DES.
  - One-cycle load latency: the first word is valid, or wi_ready rises, in the cycle after acceptance.
- SER:
  - wo_valid=1, wo_data=line_reg word[idx], wo_idx=idx, wo_last=(cnt==N-1).
  - Each wo_valid&&wo_ready: idx<=idx+1 mod N (wraps N-1 to 0), cnt<=cnt+1.
  - The transfer with wo_last=1 returns to IDLE; ld_ready=1 in the next cycle.
  - wo_data/wo_idx stay stable while wo_ready=0.
- DES:
  - wi_ready=1.
  - Each wi_valid&&wi_ready: word[idx] of line_reg<=wi_data, idx wraps mod N, cnt increments.
  - On the Nth accepted word, next state is LOUT.
- LOUT:
  - line_valid=1, line_data=line_reg, wi_ready=0.
  - Holds stable until line_ready=1; that cycle completes the transfer and the next state is IDLE.
  - line_data outside LOUT is don't-care but must not glitch during LOUT.
- Back-to-back: a new load cannot be accepted in the same cycle the previous transaction completes. Minimum gap is 1 IDLE cycle.
- ld_valid while busy is ignored (no queuing). wi_valid outside DES is ignored. wo_ready outside SER is ignored.
- Throughput: 1 word/cycle with ready held high. A serialize transaction takes N+1 cycles from acceptance to ld_ready.

Test Plan:
- Reset then serialize:
  - Stimulus: ld_line=0x11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888, offset 0, wo_ready=1.
  - Response: wo_data 0x88888888,0x77777777,...,0x11111111 on 8 consecutive cycles; wo_idx 0..7; wo_last only on 0x11111111; ld_ready high after.
- Wrap-around:
  - Stimulus: same line, offset 6.
  - Response: order 0x22222222,0x11111111,0x88888888,...,0x33333333; wo_idx 6,7,0,1,...,5; wo_last on 0x33333333.
- Backpressure:
  - Stimulus: wo_ready toggled 1,0,0,1,...
  - Response: wo_data/wo_idx held during low cycles; exactly 8 transfers, no duplicates or skips.
- Deserialize:
  - Stimulus: offset 3, words 0xA0..0xA7 with wi_valid gaps.
  - Response: line_data word3=0xA0, word4=0xA1, ..., word2=0xA7; line_valid held until line_ready pulse, then IDLE.
- Reset mid-operation:
  - Stimulus: RST_N=0 after 3 serialized words.
  - Response: next cycle wo_valid=0, ld_ready=1, busy=0; a new transaction starts cleanly from its offset.
- Ignored inputs:
  - Stimulus: ld_valid pulsed during SER; wi_valid asserted during IDLE.
  - Response: no state change; the current transaction completes unaffected.
